// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: opcode constants, format enumeration and opcode-to-format mapping.
package inst_encoder_pkg;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_CSR, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;
  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } word_t;
  function automatic fmt_t fmt_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
      OP_SYSTEM:                return FMT_CSR;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_AUIPC, OP_LUI:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_R;
    endcase
  endfunction
endpackage

// File: rtl/inst_packer.sv
// inst_packer: packs register/function/immediate fields into a 32-bit word and flags unrepresentable immediates.
module inst_packer
  import inst_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);
  fmt_t fmt;
  logic fits12, fits13, fits21;
  assign fmt = fmt_of(opcode);
  // A value fits an N-bit signed field when every bit above the field's sign bit matches it.
  assign fits12 = &imm[31:11] | ~|imm[31:11];
  assign fits13 = &imm[31:12] | ~|imm[31:12];
  assign fits21 = &imm[31:20] | ~|imm[31:20];
  always_comb begin
    inst = {f7, rs2, rs1, f3, rd, opcode};
    err  = 1'b0;
    case (fmt)
      FMT_I: begin
        inst = {imm[11:0], rs1, f3, rd, opcode};
        err  = ~fits12;
      end
      FMT_CSR: begin
        inst = {f7, rs2, imm[4:0], f3, rd, opcode};
        err  = |imm[31:5];
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
        err  = ~fits12;
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
        err  = ~fits13 | imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = ~fits21 | imm[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: encodes instruction requests into a 2-entry output FIFO with a saturating error counter.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] err_count
);
  word_t       mem [2];
  logic [1:0]  count;
  logic        rptr, wptr, push, pop, pk_err;
  logic [31:0] pk_inst;
  inst_packer u_packer (
    .opcode(in_opcode),
    .rd(in_rd),
    .rs1(in_rs1),
    .rs2(in_rs2),
    .f3(in_funct3),
    .f7(in_funct7),
    .imm(in_imm),
    .inst(pk_inst),
    .err(pk_err)
  );
  assign in_ready  = count < 2'd2;
  assign out_valid = count != 2'd0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? mem[rptr].inst : '0;
  assign out_err   = out_valid ? mem[rptr].err : 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rptr      <= 1'b0;
      wptr      <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{inst: pk_inst, err: pk_err};
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && pk_err && ~&err_count) err_count <= err_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench with directed cases and randomized requests against a reference encoder.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_count;
  int          checks = 0;
  int          failures = 0;
  int          accepted = 0;
  logic [15:0] errs = '0;
  logic [32:0] exp_q[$];
  inst_encoder dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_rd(in_rd),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_err(out_err),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference encoder built directly from the field layouts and numeric ranges.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (op)
      7'h03, 7'h13, 7'h67: return {imm[11:0], rs1, f3, rd, op, 1'(s < -2048 || s > 2047)};
      7'h73: return {f7, rs2, imm[4:0], f3, rd, op, 1'(imm > 32'd31)};
      7'h23: return {imm[11:5], rs2, rs1, f3, imm[4:0], op, 1'(s < -2048 || s > 2047)};
      7'h63: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op,
                     1'(s < -4096 || s > 4095 || imm[0])};
      7'h17, 7'h37: return {imm[31:12], rd, op, 1'(imm % 4096 != 0)};
      7'h6F: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op,
                     1'(s < -(1 << 20) || s >= (1 << 20) || imm[0])};
      default: return {f7, rs2, rs1, f3, rd, op, 1'b0};
    endcase
  endfunction
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %h expected none", out_inst);
      end else begin
        chk("out_inst", out_inst, exp_q[0][32:1]);
        chk("out_err", 32'(out_err), 32'(exp_q[0][0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic [32:0] exp, input bit kick);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (kick && n >= 2) out_ready = 1'b1;
      if (n == 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1");
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    exp_q.push_back(exp);
    if (exp[0] && errs != 16'hFFFF) errs++;
    accepted++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic send_m(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input bit kick);
    send(op, rd, rs1, rs2, f3, f7, imm, model(op, rd, rs1, rs2, f3, f7, imm), kick);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    errs = '0;
  endtask
  task automatic chk_errs(input string name);
    @(negedge clk);
    chk(name, 32'(err_count), 32'(errs));
    @(posedge clk); #1;
  endtask
  logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h33};
  logic [31:0] edges [12] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4095, 32'd4096,
                              -32'sd4096, -32'sd4097, 32'h000FFFFF, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFF};
  initial begin
    int acc0;
    logic [31:0] imm;
    logic [6:0] op;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_inst", out_inst, 0);
    chk("reset_err_count", 32'(err_count), 0);
    @(posedge clk); #1;
    send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, {32'hFFF10093, 1'b0}, 1'b0);
    @(negedge clk);
    chk("addi_latency_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, {32'h0020A423, 1'b0}, 1'b0);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, {32'h00000463, 1'b0}, 1'b0);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, {32'h00000363, 1'b1}, 1'b0);
    @(negedge clk);
    chk("beq_odd_err_count", 32'(err_count), 1);
    @(posedge clk); #1;
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, {32'h001000EF, 1'b0}, 1'b0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, {32'h123452B7, 1'b0}, 1'b0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, {32'h123452B7, 1'b1}, 1'b0);
    idle(2);
    chk_errs("directed_err_count");
    out_ready = 1'b0;
    acc0 = accepted;
    fork
      begin
        send_m(7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'd0, 1'b0);
        send_m(7'h13, 5'd6, 5'd7, 5'd0, 3'd0, 7'd0, 32'd100, 1'b0);
        send_m(7'h03, 5'd8, 5'd9, 5'd0, 3'd2, 7'd0, -32'sd4, 1'b0);
      end
    join_none
    repeat (5) @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_accepted", 32'(accepted - acc0), 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && accepted != acc0 + 3; n++) @(negedge clk);
    chk("bp_third_accepted", 32'(accepted - acc0), 3);
    idle(4);
    chk("bp_drained", 32'(exp_q.size()), 0);
    out_ready = 1'b0;
    send_m(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0);
    send_m(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    errs = '0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", 32'(out_err), 0);
    @(negedge clk);
    chk("rst_discarded_req", 32'(out_valid), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = edges[$urandom_range(0, 11)] + 32'($urandom_range(0, 2)) - 32'd1;
        3: imm = {20'($urandom), ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'd0};
        default: imm = 32'($urandom_range(0, 40));
      endcase
      out_ready = $urandom_range(0, 3) != 0;
      send_m(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    out_ready = 1'b1;
    idle(3);
    chk("random_drained", 32'(exp_q.size()), 0);
    chk_errs("random_err_count");
    do_reset();
    for (int i = 0; i < 65536; i++)
      send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, {32'h00000363, 1'b1}, 1'b1);
    idle(2);
    @(negedge clk);
    chk("sat_err_count", 32'(err_count), 32'hFFFF);
    @(posedge clk); #1;
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5000, {32'h38800013, 1'b1}, 1'b1);
    idle(2);
    @(negedge clk);
    chk("sat_err_count_hold", 32'(err_count), 32'hFFFF);
    chk("final_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
